axi4l_master_arbiter: RTL
=========================

Name: axi4l_master_arbiter

Overview:
- Shares one AXI4-Lite master port between NUM_REQ=2 simple command requesters (e.g. GPIO sequencer and config loader).
- Round-robin arbitration, one outstanding transaction at a time, local rejection of illegal commands.
- Per-requester response pulse.
- Sits in front of axi4l_interface; never drives ARVALID and AWVALID together.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI data width; strobe width DATA_WIDTH/8.
- TIMEOUT_CYCLES, 256, response-phase timeout limit (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  2  per-requester command valid
- req_ready  out  2  one-hot one-cycle pulse: command accepted
- req_write  in  2  1=write, 0=read, per requester
- req_addr  in  2*ADDR_WIDTH  packed per-requester address, requester 0 in LSBs
- req_wdata  in  2*DATA_WIDTH  packed per-requester write data
- req_wstrb  in  2*DATA_WIDTH/8  packed per-requester strobes
- rsp_valid  out  2  one-hot one-cycle pulse: response for that requester
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid, 0 for writes
- rsp_resp  out  2  00 OKAY, 10 SLVERR, 11 DECERR (timeout)
- AWADDR, AWVALID, AWREADY  out/out/in  ADDR_WIDTH/1/1  write address channel
- WDATA, WSTRB, WVALID, WREADY  out/out/out/in  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel
- BRESP, BVALID, BREADY  in/in/out  2/1/1  write response channel
- ARADDR, ARVALID, ARREADY  out/out/in  ADDR_WIDTH/1/1  read address channel
- RDATA, RRESP, RVALID, RREADY  in/in/in/out  DATA_WIDTH/2/1/1  read data channel

Behaviour:
- Reset: all outputs 0; state IDLE; rr pointer = requester 0 has priority.
- States: IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, ERR_RSP.
- Arbitration (IDLE only):
  - If any req_valid, grant per round-robin: the priority requester wins if valid, else the other.
  - Assert req_ready[grant] for one cycle and latch write/addr/wdata/wstrb.
  - Pointer moves to the other requester after each grant.
  - A requester must hold req_valid until req_ready.
- Illegal command → ERR_RSP, no bus activity:
  - Misaligned address (addr[1:0]!=0), or a write with wstrb==0.
  - Next cycle: rsp_valid pulse, rsp_resp=10, rsp_rdata=0; then IDLE.
- Write path:
  - Cycle after accept: WR_ADDR, with AWVALID and WVALID both 1.
  - Each VALID drops the cycle after its own READY handshake; AWADDR/WDATA/WSTRB are stable while VALID is 1.
  - When both handshakes are done (same or different cycles) → WR_RESP.
  - WR_RESP: BREADY=1; on BVALID → rsp_valid pulse next cycle with rsp_resp=BRESP, rsp_rdata=0; return to IDLE.
- Read path:
  - RD_ADDR: ARVALID=1 until ARREADY → RD_DATA.
  - RD_DATA: RREADY=1; on RVALID latch RDATA/RRESP, rsp_valid next cycle, IDLE.
- Latency: with AWREADY=WREADY=1 and BVALID one cycle after, accept at T gives AWVALID at T+1, BVALID at T+2, rsp_valid at T+3. Read latency is identical.
- Back-to-back: a new grant is possible the cycle rsp_valid pulses; no overlap of transactions.
- Simultaneous req_valid from both: exactly one req_ready, alternating on consecutive grants.
- Reset mid-transaction: immediate return to IDLE with all VALID/READY low; the pending command is lost with no response.

Optional Feature:
- Macro AXI4L_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in WR_RESP/RD_DATA.
  - If BVALID/RVALID is absent for TIMEOUT_CYCLES cycles, drop BREADY/RREADY, pulse rsp_valid with rsp_resp=11 and rsp_rdata=0, then IDLE.
  - Address-phase VALIDs are never aborted.
- Undefined: no counter; the block waits indefinitely.

Decomposition:
- Package axi4l_arb_pkg:
  - state enum.
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - Command struct {write, addr, wdata, wstrb}.
- Sub-module rr_arbiter_2:
  - Inputs: req[1:0], advance.
  - Output: one-hot grant.
  - Owns the rotating priority pointer.

Test Plan:
- Req0 write addr 0x10, data 0xDEADBEEF, strobe 0xF; slave ready immediately, BRESP 00 → AW/W at T+1, rsp_valid[0] at T+3, resp 00.
- Req1 read 0x20; ARREADY delayed 3 cycles; RDATA 0x12345678, RRESP 00 → ARVALID held 3 cycles stable, rsp_rdata 0x12345678 to requester 1 only.
- Both requesters hold valid for 4 transactions → grants 0,1,0,1; ARVALID and AWVALID never high together.
- Req0 write addr 0x13, then write with strobe 0 → no AWVALID; rsp_resp 10 each, one cycle after accept.
- WREADY 2 cycles before AWREADY → WVALID drops first; BREADY rises only after both handshakes.
- With AXI4L_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, BVALID never returned → rsp_resp 11 after 8 cycles; next request served normally.

Source files
------------

// File: rtl/axi4l_arb_pkg.sv
// Shared types and constants for the AXI4-Lite two-requester master arbiter.
package axi4l_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ADDR = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_ERR_RSP = 3'd5
    } arb_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Field widths of the latched command; these bound the widest bus the arbiter supports.
    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;
    localparam int ARB_STRB_W = ARB_DATA_W / 8;

    typedef struct packed {
        logic                  write;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
        logic [ARB_STRB_W-1:0] wstrb;
    } arb_cmd_t;

    // A command is rejected locally if it is not word aligned or is a write with no lanes enabled.
    function automatic logic cmd_illegal(input logic write, input logic [1:0] addr_lsb,
                                         input logic strb_zero);
        return (addr_lsb != 2'b00) || (write && strb_zero);
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter; the pointer names the requester that currently has priority.
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic r_ptr;

    // Priority requester wins if it is asking, otherwise the other one.
    always_comb begin
        grant = 2'b00;
        if (!r_ptr) begin
            if (req[0])      grant = 2'b01;
            else if (req[1]) grant = 2'b10;
        end else begin
            if (req[1])      grant = 2'b10;
            else if (req[0]) grant = 2'b01;
        end
    end

    // After a grant, priority passes to the requester that was not served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     r_ptr <= 1'b0;
        else if (advance && |grant)  r_ptr <= grant[0];
    end

endmodule

// File: rtl/axi4l_master_arbiter.sv
// Shares one AXI4-Lite master port between two command requesters, one transaction at a time.
// Build option: define AXI4L_ARB_TIMEOUT_EN to abort a response wait after TIMEOUT_CYCLES
// cycles with a DECERR response; otherwise the response phase waits indefinitely.
module axi4l_master_arbiter
    import axi4l_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = ARB_ADDR_W,
    parameter int DATA_WIDTH     = ARB_DATA_W,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                req_valid,
    output logic [1:0]                req_ready,
    input  logic [1:0]                req_write,
    input  logic [2*ADDR_WIDTH-1:0]   req_addr,
    input  logic [2*DATA_WIDTH-1:0]   req_wdata,
    input  logic [2*DATA_WIDTH/8-1:0] req_wstrb,
    output logic [1:0]                rsp_valid,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic [ADDR_WIDTH-1:0]     AWADDR,
    output logic                      AWVALID,
    input  logic                      AWREADY,
    output logic [DATA_WIDTH-1:0]     WDATA,
    output logic [DATA_WIDTH/8-1:0]   WSTRB,
    output logic                      WVALID,
    input  logic                      WREADY,
    input  logic [1:0]                BRESP,
    input  logic                      BVALID,
    output logic                      BREADY,
    output logic [ADDR_WIDTH-1:0]     ARADDR,
    output logic                      ARVALID,
    input  logic                      ARREADY,
    input  logic [DATA_WIDTH-1:0]     RDATA,
    input  logic [1:0]                RRESP,
    input  logic                      RVALID,
    output logic                      RREADY
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    arb_state_t              r_state, w_state_nxt;
    arb_cmd_t                r_cmd, w_cmd_sel;
    logic [1:0]              w_grant;
    logic                    w_advance;
    logic                    w_sel_write;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;
    logic [DATA_WIDTH-1:0]   w_sel_wdata;
    logic [STRB_WIDTH-1:0]   w_sel_wstrb;
    logic                    w_illegal;
    logic [1:0]              r_owner;
    logic                    r_aw_done, r_w_done;
    logic                    w_rsp_set;
    logic [1:0]              w_rsp_resp;
    logic [DATA_WIDTH-1:0]   w_rsp_rdata;
    logic [1:0]              r_rsp_onehot, r_rsp_resp;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;
    logic                    w_timeout;

    assign w_advance = (r_state == ST_IDLE);

    rr_arbiter_2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (w_advance),
        .grant   (w_grant)
    );

    assign w_sel_write = w_grant[1] ? req_write[1] : req_write[0];
    assign w_sel_addr  = w_grant[1] ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
    assign w_sel_wdata = w_grant[1] ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
    assign w_sel_wstrb = w_grant[1] ? req_wstrb[2*STRB_WIDTH-1:STRB_WIDTH] : req_wstrb[STRB_WIDTH-1:0];
    assign w_illegal   = cmd_illegal(w_sel_write, w_sel_addr[1:0], w_sel_wstrb == '0);

    // Pack the granted requester's command for latching.
    always_comb begin
        w_cmd_sel       = '0;
        w_cmd_sel.write = w_sel_write;
        w_cmd_sel.addr  = ARB_ADDR_W'(w_sel_addr);
        w_cmd_sel.wdata = ARB_DATA_W'(w_sel_wdata);
        w_cmd_sel.wstrb = ARB_STRB_W'(w_sel_wstrb);
    end

    assign AWADDR    = r_cmd.addr[ADDR_WIDTH-1:0];
    assign ARADDR    = r_cmd.addr[ADDR_WIDTH-1:0];
    assign WDATA     = r_cmd.wdata[DATA_WIDTH-1:0];
    assign WSTRB     = r_cmd.wstrb[STRB_WIDTH-1:0];
    assign rsp_valid = r_rsp_onehot;
    assign rsp_resp  = r_rsp_resp;
    assign rsp_rdata = r_rsp_rdata;

`ifdef AXI4L_ARB_TIMEOUT_EN
    localparam int                 TIMER_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TIMER_W-1:0] TIMER_INIT = TIMER_W'(TIMEOUT_CYCLES - 1);
    logic [TIMER_W-1:0] r_timer;

    // Down-counter armed outside the response waits, expiring at zero inside them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_timer <= TIMER_INIT;
        else if (r_state == ST_WR_RESP || r_state == ST_RD_DATA)
            r_timer <= r_timer - TIMER_W'(1);
        else
            r_timer <= TIMER_INIT;
    end

    assign w_timeout = (r_timer == '0);
`else
    assign w_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state, bus handshake outputs and response capture request.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 2'b00;
        AWVALID     = 1'b0;
        WVALID      = 1'b0;
        BREADY      = 1'b0;
        ARVALID     = 1'b0;
        RREADY      = 1'b0;
        w_rsp_set   = 1'b0;
        w_rsp_resp  = RESP_OKAY;
        w_rsp_rdata = '0;
        case (r_state)
            ST_IDLE: begin
                req_ready = w_grant;
                if (|w_grant) begin
                    if (w_illegal) begin
                        w_state_nxt = ST_ERR_RSP;
                        w_rsp_set   = 1'b1;
                        w_rsp_resp  = RESP_SLVERR;
                    end else if (w_sel_write) begin
                        w_state_nxt = ST_WR_ADDR;
                    end else begin
                        w_state_nxt = ST_RD_ADDR;
                    end
                end
            end
            ST_WR_ADDR: begin
                AWVALID = !r_aw_done;
                WVALID  = !r_w_done;
                if ((r_aw_done || AWREADY) && (r_w_done || WREADY))
                    w_state_nxt = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                BREADY = 1'b1;
                if (BVALID) begin
                    w_state_nxt = ST_IDLE;
                    w_rsp_set   = 1'b1;
                    w_rsp_resp  = BRESP;
                end else if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                    w_rsp_set   = 1'b1;
                    w_rsp_resp  = RESP_DECERR;
                end
            end
            ST_RD_ADDR: begin
                ARVALID = 1'b1;
                if (ARREADY) w_state_nxt = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                RREADY = 1'b1;
                if (RVALID) begin
                    w_state_nxt = ST_IDLE;
                    w_rsp_set   = 1'b1;
                    w_rsp_resp  = RRESP;
                    w_rsp_rdata = RDATA;
                end else if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                    w_rsp_set   = 1'b1;
                    w_rsp_resp  = RESP_DECERR;
                end
            end
            ST_ERR_RSP: w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Command latch, per-channel handshake tracking and registered one-cycle response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd        <= '0;
            r_owner      <= 2'b00;
            r_aw_done    <= 1'b0;
            r_w_done     <= 1'b0;
            r_rsp_onehot <= 2'b00;
            r_rsp_resp   <= RESP_OKAY;
            r_rsp_rdata  <= '0;
        end else begin
            if (r_state == ST_IDLE && |w_grant) begin
                r_cmd   <= w_cmd_sel;
                r_owner <= w_grant;
            end
            r_aw_done    <= (r_state == ST_WR_ADDR) && (r_aw_done || AWREADY);
            r_w_done     <= (r_state == ST_WR_ADDR) && (r_w_done || WREADY);
            r_rsp_onehot <= w_rsp_set ? ((r_state == ST_IDLE) ? w_grant : r_owner) : 2'b00;
            r_rsp_resp   <= w_rsp_resp;
            r_rsp_rdata  <= w_rsp_rdata;
        end
    end

endmodule
